// File: rtl/fixed_point_sample_gen.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : fixed_point_sample_gen
// Brief    : Rate-divided ramp/square/impulse/noise sample source, valid/ready out
// Revision : 1.0 - initial release
//==============================================================================
module fixed_point_sample_gen #(
   parameter int         DATA_W    = 8,
   parameter int         RATE_DIV  = 1350000,
   parameter int         RAMP_STEP = 1,
   parameter int         SQ_HALF   = 8,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [1:0]        i_mode,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_busy,
   output logic [7:0]        o_overrun
);

   localparam int                c_CNT_W    = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RATE_DIV - 1);
   localparam logic [DATA_W-1:0] c_POS_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] c_NEG_MAX  = ~c_POS_MAX + DATA_W'(1);
   localparam logic [DATA_W-1:0] c_RAMP_INC = DATA_W'(RAMP_STEP);
   localparam logic [7:0]        c_SQ_LAST  = 8'(SQ_HALF - 1);
   localparam logic [1:0]        c_MODE_RAMP    = 2'd0;
   localparam logic [1:0]        c_MODE_SQUARE  = 2'd1;
   localparam logic [1:0]        c_MODE_IMPULSE = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TICK = 2'd1,
      PRESENT   = 2'd2
   } state_t;

   state_t              r_state,    w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
   logic [1:0]          r_mode,     w_mode_nxt;
   logic [DATA_W-1:0]   r_data,     w_data_nxt;
   logic                r_valid,    w_valid_nxt;
   logic [7:0]          r_overrun,  w_overrun_nxt;
   logic [DATA_W-1:0]   r_ramp,     w_ramp_nxt;
   logic [7:0]          r_sq_cnt,   w_sq_cnt_nxt;
   logic                r_sq_neg,   w_sq_neg_nxt;
   logic                r_imp_done, w_imp_done_nxt;
   logic [7:0]          r_lfsr,     w_lfsr_nxt;

   logic                w_tick;
   logic                w_hs;
   logic                w_load;
   logic                w_restart;
   logic                w_lfsr_fb;
   logic [DATA_W-1:0]   w_noise;
   logic [DATA_W-1:0]   w_sample;

   assign w_tick    = (r_state != IDLE) && (r_cnt == c_CNT_LAST);
   assign w_hs      = r_valid && i_ready;
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   // The 8-bit LFSR fills the sample from the MSB down so it stays a full-scale value.
   generate
      if (DATA_W >= 8) begin : g_noise_wide
         assign w_noise = DATA_W'(r_lfsr) << (DATA_W - 8);
      end else begin : g_noise_narrow
         assign w_noise = r_lfsr[7 -: DATA_W];
      end
   endgenerate

   always_comb begin
      w_sample = '0;
      case (r_mode)
         c_MODE_RAMP:    w_sample = r_ramp;
         c_MODE_SQUARE:  w_sample = r_sq_neg ? c_NEG_MAX : c_POS_MAX;
         c_MODE_IMPULSE: w_sample = r_imp_done ? '0 : c_POS_MAX;
         default:        w_sample = w_noise;
      endcase
   end

   // Next-state and output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_mode_nxt    = r_mode;
      w_valid_nxt   = r_valid;
      w_data_nxt    = r_data;
      w_overrun_nxt = r_overrun;
      w_load        = 1'b0;
      w_restart     = 1'b0;

      case (r_state)
         IDLE: begin
            if (i_enable) begin
               w_state_nxt = WAIT_TICK;
               w_mode_nxt  = i_mode;
               w_restart   = 1'b1;
            end
         end
         WAIT_TICK: begin
            if (!i_enable) begin
               w_state_nxt = IDLE;
            end else if (w_tick) begin
               w_load      = 1'b1;
               w_valid_nxt = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (w_hs && !i_enable) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end else if (w_hs && w_tick) begin
               w_load = 1'b1;
            end else if (w_hs) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = WAIT_TICK;
            end else if (w_tick && (r_overrun != 8'hFF)) begin
               w_overrun_nxt = r_overrun + 8'd1;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase

      if (w_load) begin
         w_data_nxt = w_sample;
      end
   end

   // Tick divider runs only while the block is active and restarts at every start.
   always_comb begin
      if ((r_state == IDLE) || (w_state_nxt == IDLE) || w_tick) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end
   end

   always_comb begin
      w_ramp_nxt     = r_ramp;
      w_sq_cnt_nxt   = r_sq_cnt;
      w_sq_neg_nxt   = r_sq_neg;
      w_imp_done_nxt = r_imp_done;
      w_lfsr_nxt     = r_lfsr;

      if (w_restart) begin
         w_ramp_nxt     = '0;
         w_sq_cnt_nxt   = 8'd0;
         w_sq_neg_nxt   = 1'b0;
         w_imp_done_nxt = 1'b0;
         w_lfsr_nxt     = LFSR_SEED;
      end else if (w_load) begin
         w_ramp_nxt     = r_ramp + c_RAMP_INC;
         w_imp_done_nxt = 1'b1;
         w_lfsr_nxt     = {r_lfsr[6:0], w_lfsr_fb};
         if (r_sq_cnt == c_SQ_LAST) begin
            w_sq_cnt_nxt = 8'd0;
            w_sq_neg_nxt = ~r_sq_neg;
         end else begin
            w_sq_cnt_nxt = r_sq_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_mode     <= c_MODE_RAMP;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_overrun  <= 8'd0;
         r_ramp     <= '0;
         r_sq_cnt   <= 8'd0;
         r_sq_neg   <= 1'b0;
         r_imp_done <= 1'b0;
         r_lfsr     <= LFSR_SEED;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mode     <= w_mode_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_overrun  <= w_overrun_nxt;
         r_ramp     <= w_ramp_nxt;
         r_sq_cnt   <= w_sq_cnt_nxt;
         r_sq_neg   <= w_sq_neg_nxt;
         r_imp_done <= w_imp_done_nxt;
         r_lfsr     <= w_lfsr_nxt;
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_busy    = (r_state != IDLE);
   assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_sample_gen.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_fixed_point_sample_gen
// Brief    : Randomised self-checking bench against a sample-level reference model
// Revision : 1.0 - initial release
//==============================================================================
module tb_fixed_point_sample_gen;

   localparam int         DATA_W    = 8;
   localparam int         RATE_DIV  = 4;
   localparam int         RAMP_STEP = 1;
   localparam int         SQ_HALF   = 2;
   localparam logic [7:0] SEED      = 8'hA5;

   logic       i_clk    = 1'b0;
   logic       i_reset  = 1'b0;
   logic       i_enable = 1'b0;
   logic [1:0] i_mode   = 2'd0;
   logic       i_ready  = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_busy;
   logic [7:0] o_overrun;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: block activity, pending sample and its value, samples generated.
   logic       m_running = 1'b0;
   logic       m_pending = 1'b0;
   logic [1:0] m_mode    = 2'd0;
   logic [7:0] m_data    = 8'd0;
   logic [7:0] m_overrun = 8'd0;
   int         m_n       = 0;
   int         m_k       = 0;
   logic [7:0] noise_ref [512];

   logic [7:0] acc_q [$];
   int         acc_t [$];

   fixed_point_sample_gen #(
      .DATA_W   (DATA_W),
      .RATE_DIV (RATE_DIV),
      .RAMP_STEP(RAMP_STEP),
      .SQ_HALF  (SQ_HALF),
      .LFSR_SEED(SEED)
   ) dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_mode   (i_mode),
      .i_ready  (i_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_busy   (o_busy),
      .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ref_sample(input logic [1:0] mode, input int n);
      case (mode)
         2'd0:    return 8'(n * RAMP_STEP);
         2'd1:    return (((n / SQ_HALF) % 2) == 0) ? 8'h7F : 8'h81;
         2'd2:    return (n == 0) ? 8'h7F : 8'h00;
         default: return noise_ref[n % 512];
      endcase
   endfunction

   // Advance the model across the coming rising edge, log handshakes, then move the clock.
   task automatic step();
      logic tick;
      logic hs;
      if (o_valid && i_ready) begin
         acc_q.push_back(o_data);
         acc_t.push_back(cyc);
      end
      if (i_reset) begin
         m_running = 1'b0;
         m_pending = 1'b0;
         m_data    = 8'd0;
         m_overrun = 8'd0;
      end else if (!m_running) begin
         if (i_enable) begin
            m_running = 1'b1;
            m_mode    = i_mode;
            m_n       = 0;
            m_k       = 0;
         end
      end else begin
         m_k  = m_k + 1;
         tick = ((m_k % RATE_DIV) == 0);
         hs   = m_pending && i_ready;
         if (!m_pending) begin
            if (!i_enable) begin
               m_running = 1'b0;
            end else if (tick) begin
               m_data    = ref_sample(m_mode, m_n);
               m_n       = m_n + 1;
               m_pending = 1'b1;
            end
         end else if (hs && !i_enable) begin
            m_pending = 1'b0;
            m_running = 1'b0;
         end else if (hs && tick) begin
            m_data = ref_sample(m_mode, m_n);
            m_n    = m_n + 1;
         end else if (hs) begin
            m_pending = 1'b0;
         end else if (tick && (m_overrun != 8'hFF)) begin
            m_overrun = m_overrun + 8'd1;
         end
      end
      @(posedge i_clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic go_idle();
      i_enable = 1'b0;
      i_ready  = 1'b1;
      for (int i = 0; i < 16 && (m_running || o_busy); i++) step();
   endtask

   task automatic test_reset();
      #2;
      i_reset = 1'b1;
      #1;
      checks++;
      if ({o_busy, o_valid, o_overrun, o_data} !== 18'd0) begin
         errors++;
         $display("FAIL reset_async got busy=%b valid=%b ovr=%0d data=%h want all zero", o_busy, o_valid, o_overrun, o_data);
      end
      step();
      step();
      i_reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_overrun !== 8'd0 || o_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold got busy=%b valid=%b ovr=%0d data=%h want all zero", o_busy, o_valid, o_overrun, o_data);
         end
      end
   endtask

   task automatic test_ramp();
      int t0;
      go_idle();
      i_mode = 2'd0; i_enable = 1'b1; i_ready = 1'b1;
      acc_q.delete(); acc_t.delete(); t0 = cyc;
      for (int i = 0; i < 600 && acc_q.size() < 130; i++) begin
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL ramp_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      checks++;
      if (acc_q.size() < 130) begin
         errors++;
         $display("FAIL ramp_count got %0d samples want 130", acc_q.size());
      end else begin
         checks++;
         if (acc_t[0] - t0 != 5) begin
            errors++;
            $display("FAIL ramp_latency got %0d cycles want 5", acc_t[0] - t0);
         end
         for (int i = 0; i < 130; i++) begin
            checks++;
            if (acc_q[i] !== 8'(i)) begin
               errors++;
               $display("FAIL ramp_value idx=%0d got %h want %h", i, acc_q[i], 8'(i));
            end
         end
         for (int i = 1; i < 130; i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] != RATE_DIV) begin
               errors++;
               $display("FAIL ramp_interval idx=%0d got %0d want %0d", i, acc_t[i] - acc_t[i-1], RATE_DIV);
            end
         end
         checks++;
         if (acc_q[127] !== 8'h7F || acc_q[128] !== 8'h80) begin
            errors++;
            $display("FAIL ramp_wrap got %h,%h want 7f,80", acc_q[127], acc_q[128]);
         end
      end
   endtask

   task automatic test_square();
      logic [7:0] exp_sq [6];
      exp_sq = '{8'h7F, 8'h7F, 8'h81, 8'h81, 8'h7F, 8'h7F};
      go_idle();
      i_mode = 2'd1; i_enable = 1'b1; i_ready = 1'b1;
      acc_q.delete(); acc_t.delete();
      for (int i = 0; i < 60 && acc_q.size() < 6; i++) begin
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL square_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (i >= acc_q.size()) begin
            errors++;
            $display("FAIL square_value idx=%0d got none want %h", i, exp_sq[i]);
         end else if (acc_q[i] !== exp_sq[i]) begin
            errors++;
            $display("FAIL square_value idx=%0d got %h want %h", i, acc_q[i], exp_sq[i]);
         end
      end
   endtask

   task automatic test_impulse();
      logic [7:0] exp_imp [4];
      exp_imp = '{8'h7F, 8'h00, 8'h00, 8'h00};
      for (int run = 0; run < 2; run++) begin
         go_idle();
         checks++;
         if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL impulse_idle run=%0d got busy=%b want 0", run, o_busy);
         end
         i_mode = 2'd2; i_enable = 1'b1; i_ready = 1'b1;
         acc_q.delete(); acc_t.delete();
         for (int i = 0; i < 40 && acc_q.size() < 4; i++) begin
            step();
            i_mode = 2'd0;  // must be ignored: mode is latched at start
            checks++;
            if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
               errors++;
               $display("FAIL impulse_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
            end
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_imp[i]) begin
               errors++;
               $display("FAIL impulse_value run=%0d idx=%0d got %h want %h", run, i, (i < acc_q.size()) ? acc_q[i] : 8'hXX, exp_imp[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      go_idle();
      i_mode = 2'd0; i_enable = 1'b1; i_ready = 1'b0;
      acc_q.delete(); acc_t.delete();
      for (int i = 0; i < 12 && !o_valid; i++) step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h00) begin
         errors++;
         $display("FAIL b2b_first got valid=%b data=%h want 1,00", o_valid, o_data);
      end
      for (int i = 0; i < 4; i++) begin
         i_ready = (i == 3);
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL b2b_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h01 || o_overrun !== m_overrun) begin
         errors++;
         $display("FAIL b2b_reload got valid=%b data=%h ovr=%0d want 1,01,%0d", o_valid, o_data, o_overrun, m_overrun);
      end
      step();
      checks++;
      if (acc_q.size() != 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'h01) begin
         errors++;
         $display("FAIL b2b_accepted got %0d samples want 2 (00,01)", acc_q.size());
      end
   endtask

   task automatic test_overrun();
      i_enable = 1'b0; i_ready = 1'b0;
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      i_mode = 2'd0; i_enable = 1'b1;
      acc_q.delete(); acc_t.delete();
      for (int i = 0; i < 12 && !o_valid; i++) step();
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL overrun_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h00 || o_overrun < 8'd4 || o_overrun > 8'd5) begin
         errors++;
         $display("FAIL overrun_hold got valid=%b data=%h ovr=%0d want 1,00,4..5", o_valid, o_data, o_overrun);
      end
      i_ready = 1'b1;
      for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
      checks++;
      if (acc_q.size() != 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'h01) begin
         errors++;
         $display("FAIL overrun_resume got %0d samples want 2 (00,01)", acc_q.size());
      end
   endtask

   task automatic test_saturate();
      i_ready = 1'b0;
      for (int i = 0; i < 12 && !o_valid; i++) step();
      for (int i = 0; i < 1100; i++) begin
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL saturate_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      checks++;
      if (o_overrun !== 8'hFF || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL saturate_final got ovr=%0d valid=%b want 255,1", o_overrun, o_valid);
      end
   endtask

   task automatic test_reset_mid();
      i_enable = 1'b0;
      i_reset  = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || o_overrun !== 8'd0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got valid=%b data=%h ovr=%0d busy=%b want 0,00,0,0", o_valid, o_data, o_overrun, o_busy);
      end
      step();
      i_reset = 1'b0;
      i_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle t=%0d (got/want) busy=%b/%b valid=%b/0 ovr=%0d/%0d", cyc, o_busy, m_running, o_valid, o_overrun, m_overrun);
         end
      end
      i_mode = 2'd0; i_enable = 1'b1;
      acc_q.delete(); acc_t.delete();
      for (int i = 0; i < 20 && acc_q.size() < 1; i++) step();
      checks++;
      if (acc_q.size() != 1 || acc_q[0] !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_restart got %0d samples want 1 (00)", acc_q.size());
      end
   endtask

   task automatic test_noise();
      go_idle();
      i_mode = 2'd3; i_enable = 1'b1;
      acc_q.delete(); acc_t.delete();
      for (int i = 0; i < 4000 && acc_q.size() < 300; i++) begin
         i_ready = ($urandom_range(0, 9) < 7);
         step();
         checks++;
         if (o_busy !== m_running || o_valid !== m_pending || o_overrun !== m_overrun || (m_pending && o_data !== m_data)) begin
            errors++;
            $display("FAIL noise_cycle t=%0d (got/want) busy=%b/%b valid=%b/%b ovr=%0d/%0d data=%h/%h", cyc, o_busy, m_running, o_valid, m_pending, o_overrun, m_overrun, o_data, m_data);
         end
      end
      checks++;
      if (acc_q.size() < 300) begin
         errors++;
         $display("FAIL noise_count got %0d samples want 300", acc_q.size());
      end else begin
         for (int i = 0; i < 300; i++) begin
            checks++;
            if (acc_q[i] !== noise_ref[i] || acc_q[i] === 8'h00) begin
               errors++;
               $display("FAIL noise_value idx=%0d got %h want %h (nonzero)", i, acc_q[i], noise_ref[i]);
            end
         end
         for (int i = 0; i < 45; i++) begin
            checks++;
            if (acc_q[i + 255] !== acc_q[i]) begin
               errors++;
               $display("FAIL noise_period idx=%0d got %h want %h", i + 255, acc_q[i + 255], acc_q[i]);
            end
         end
      end
      go_idle();
   endtask

   initial begin
      logic [7:0] s;
      s = SEED;
      for (int i = 0; i < 512; i++) begin
         noise_ref[i] = s;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      test_reset();
      test_ramp();
      test_square();
      test_impulse();
      test_back_to_back();
      test_overrun();
      test_saturate();
      test_reset_mid();
      test_noise();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
